ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Parametrised successor to the PS2 keyboard receive/decode path.
- Consumes bytes from the PS2 receiver (din qualified by rx_done_tick) and parses make, break (F0) and extended (E0) prefix sequences.
- Keeps a held/released state for a configurable table of keys.
- Queues press/release events in a small FIFO with a valid/ready handshake, so downstream logic never misses a key edge.

Parameters:
- NUM_KEYS, 4, number of tracked keys (1..16).
- KEY_CODES, {8'h33,8'h24,8'h16,8'h2C}, packed NUM_KEYS*8 scan codes; key i uses bits [8i+7:8i].
- KEY_EXT, 4'b0000, per-key flag; 1 means the key's code must be preceded by E0.
- EVQ_DEPTH, 4, event FIFO depth; must be a power of two, 2..16.
- KIDX_W, 2, width of the key index; must be at least clog2(NUM_KEYS), minimum 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- din  in  8  received scan-code byte; valid only when rx_done_tick=1.
- rx_done_tick  in  1  one-cycle strobe from the PS2 receiver.
- key_down  out  NUM_KEYS  registered held state per key.
- key_pulse  out  NUM_KEYS  one-cycle strobe on a key's make edge.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_key  out  KIDX_W  key index of the head event.
- evt_make  out  1  head event type: 1 = press, 0 = release.
- evt_overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
- ovf_clr  in  1  clears evt_overflow.

Behaviour:
- Reset (async assert, sync release):
  - Parser state is IDLE.
  - key_down=0, key_pulse=0, FIFO empty, evt_valid=0, evt_key=0, evt_make=0, evt_overflow=0.
- Byte capture: din is sampled only in cycles with rx_done_tick=1. Other cycles leave the parser untouched.
- Parser FSM (transitions happen only on rx_done_tick):
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> resolve(code, ext=0, make=1), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> resolve(ext=1, make=1) -> IDLE.
  - BRK: any byte except E0/F0 -> resolve(ext=0, make=0) -> IDLE. E0 or F0 -> IDLE with no action (protocol error).
  - EXT_BRK: any byte except E0/F0 -> resolve(ext=1, make=0) -> IDLE. E0 or F0 -> IDLE with no action.
- Resolve:
  - Match rule: lowest index i where KEY_CODES[i]==code and KEY_EXT[i]==ext. No match means no action; 0xAA, 0xFA and E1 fall through as unmatched.
  - Make on a released key: key_down[i]<=1, key_pulse[i]=1 for one cycle, push event {i,1}.
  - Make on an already-held key (typematic repeat): no change, no pulse, no event (see Optional Feature).
  - Break on a held key: key_down[i]<=0, push event {i,0}.
  - Break on a released key: ignored.
- Latency: the rx_done_tick that completes a sequence is cycle n. key_down, key_pulse and evt_valid change at the clock edge ending cycle n, so they are visible in cycle n+1.
- FIFO:
  - First-word-fall-through: evt_key/evt_make show the head whenever evt_valid=1.
  - Pop when evt_valid & evt_ready.
  - Push while full: the new event is dropped and evt_overflow<=1; stored contents are unchanged.
  - Push and pop in the same cycle while full: both succeed and occupancy is unchanged.
  - Push and pop in the same cycle while empty is impossible because a push is not visible until the next cycle.
  - Pointers wrap modulo EVQ_DEPTH.
- evt_overflow: cleared by ovf_clr. If ovf_clr and an overflow occur in the same cycle, set wins.
- Reset mid-sequence (for example after E0 or F0): the partial prefix is discarded, all keys are released, and no release events are generated.

Optional Feature:
- Macro: PS2_TYPEMATIC_EN.
- Defined: a make on an already-held key asserts key_pulse[i] and pushes event {i,1}; key_down stays 1.
- Undefined: repeats are silently absorbed, as described in Behaviour.

Test Plan:
- Press/release: rx bytes 2C, F0, 2C with evt_ready=1 -> key_down[0] rises then falls; key_pulse[0] high for one cycle; events {0,1} then {0,0}.
- Extended key: KEY_EXT=4'b0010, KEY_CODES[1]=8'h75; send 75 -> no action; send E0,75 -> key_down[1]=1; send E0,F0,75 -> key_down[1]=0 with events {1,1},{1,0}.
- Typematic: send 24,24,24 -> one event, one key_pulse[2] when the macro is undefined; three events and three pulses with PS2_TYPEMATIC_EN.
- Overflow: evt_ready=0, EVQ_DEPTH=4, five press/release events -> evt_valid=1, 4 entries kept (first four), evt_overflow=1; ovf_clr clears it; draining yields the four oldest events in order.
- Full plus simultaneous pop: FIFO full, evt_ready=1 in the same cycle as a new push -> no overflow, occupancy stays 4, order preserved.
- Reset mid-sequence: send F0, assert reset low for 2 cycles, release, send 2C -> treated as a make (key_down[0]=1), not a break.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: parses PS2 make/break/extended scan-code sequences, tracks a held/released
// state for a table of keys and queues press/release events in a first-word-fall-through FIFO.
// Optional feature macro: PS2_TYPEMATIC_EN. When defined, a make on an already-held key pulses
// and queues a press event. When undefined, such repeats are absorbed.
module ps2_key_tracker #(
  parameter int unsigned                NUM_KEYS  = 4,
  parameter logic [NUM_KEYS*8-1:0]      KEY_CODES = {8'h33, 8'h24, 8'h16, 8'h2C},
  parameter logic [NUM_KEYS-1:0]        KEY_EXT   = '0,
  parameter int unsigned                EVQ_DEPTH = 4,
  parameter int unsigned                KIDX_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          din,
  input  logic                rx_done_tick,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KIDX_W-1:0]   evt_key,
  output logic                evt_make,
  output logic                evt_overflow,
  input  logic                ovf_clr
);

  localparam int unsigned PtrW = $clog2(EVQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EvtW = KIDX_W + 1;

  localparam logic [7:0] CodeExt = 8'hE0;
  localparam logic [7:0] CodeBrk = 8'hF0;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e              state_q, state_d;
  logic [NUM_KEYS-1:0] key_down_q, key_down_d;
  logic [NUM_KEYS-1:0] key_pulse_q, key_pulse_d;
  logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [EvtW-1:0]     mem_q [EVQ_DEPTH];

  logic                res_en, res_ext, res_make;
  logic                hit, held;
  logic [NUM_KEYS-1:0] hit_vec;
  logic [KIDX_W-1:0]   hit_idx;
  logic                push, push_make, push_ok, pop, full;
  logic [EvtW-1:0]     head;

  // Parser: advance on each received byte and flag a completed sequence for resolution.
  always_comb begin
    state_d  = state_q;
    res_en   = 1'b0;
    res_ext  = 1'b0;
    res_make = 1'b0;
    if (rx_done_tick) begin
      unique case (state_q)
        StIdle: begin
          if (din == CodeExt)      state_d = StExt;
          else if (din == CodeBrk) state_d = StBrk;
          else begin
            res_en   = 1'b1;
            res_make = 1'b1;
          end
        end
        StExt: begin
          if (din == CodeBrk)      state_d = StExtBrk;
          else if (din != CodeExt) begin
            res_en   = 1'b1;
            res_ext  = 1'b1;
            res_make = 1'b1;
            state_d  = StIdle;
          end
        end
        StBrk: begin
          // A prefix byte here is a protocol error: drop the sequence.
          res_en  = (din != CodeExt) && (din != CodeBrk);
          state_d = StIdle;
        end
        StExtBrk: begin
          res_en  = (din != CodeExt) && (din != CodeBrk);
          res_ext = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Key lookup: lowest-index entry whose code and extended flag both match.
  always_comb begin
    hit     = 1'b0;
    hit_vec = '0;
    hit_idx = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (!hit && (KEY_CODES[8*i +: 8] == din) && (KEY_EXT[i] == res_ext)) begin
        hit        = 1'b1;
        hit_vec[i] = 1'b1;
        hit_idx    = KIDX_W'(i);
      end
    end
    held = |(key_down_q & hit_vec);
  end

  // Key state update and event generation for a resolved sequence.
  always_comb begin
    key_down_d  = key_down_q;
    key_pulse_d = '0;
    push        = 1'b0;
    push_make   = 1'b0;
    if (res_en && hit) begin
      if (res_make) begin
        if (!held) begin
          key_down_d  = key_down_q | hit_vec;
          key_pulse_d = hit_vec;
          push        = 1'b1;
          push_make   = 1'b1;
        end
`ifdef PS2_TYPEMATIC_EN
        else begin
          key_pulse_d = hit_vec;
          push        = 1'b1;
          push_make   = 1'b1;
        end
`endif
      end else if (held) begin
        key_down_d = key_down_q & ~hit_vec;
        push       = 1'b1;
      end
    end
  end

  // Event FIFO bookkeeping; a pop while full frees the slot for a same-cycle push.
  always_comb begin
    full    = (count_q == CntW'(EVQ_DEPTH));
    pop     = (count_q != '0) && evt_ready;
    push_ok = push && (!full || pop);
    wptr_d  = push_ok ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CntW'(1);
    else if (!push_ok && pop) count_d = count_q - CntW'(1);
    ovf_d = ovf_q;
    if (ovf_clr)              ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      key_down_q  <= '0;
      key_pulse_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_down_q  <= key_down_d;
      key_pulse_q <= key_pulse_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= {hit_idx, push_make};
  end

  // Outputs: head shown only while valid so an empty FIFO reads as zero.
  always_comb begin
    head         = mem_q[rptr_q];
    evt_valid    = (count_q != '0);
    evt_key      = evt_valid ? head[EvtW-1:1] : '0;
    evt_make     = evt_valid & head[0];
    key_down     = key_down_q;
    key_pulse    = key_pulse_q;
    evt_overflow = ovf_q;
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed test-plan sequences followed by random
// traffic, checked cycle by cycle against a behavioural model and an event scoreboard.
module tb_ps2_key_tracker;

  localparam int NK    = 4;
  localparam int DEPTH = 4;
  localparam int KW    = 2;
`ifdef PS2_TYPEMATIC_EN
  localparam bit Typematic = 1'b1;
`else
  localparam bit Typematic = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     din;
  logic           rx_done_tick, evt_ready, ovf_clr;
  logic [NK-1:0]  key_down, key_pulse;
  logic           evt_valid, evt_make, evt_overflow;
  logic [KW-1:0]  evt_key;

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .NUM_KEYS (NK),
    .KEY_CODES({8'h33, 8'h24, 8'h75, 8'h2C}),
    .KEY_EXT  (4'b0010),
    .EVQ_DEPTH(DEPTH),
    .KIDX_W   (KW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .rx_done_tick(rx_done_tick),
    .key_down    (key_down),
    .key_pulse   (key_pulse),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_key     (evt_key),
    .evt_make    (evt_make),
    .evt_overflow(evt_overflow),
    .ovf_clr     (ovf_clr)
  );

  // Reference key table.
  byte unsigned codes[NK] = '{8'h2C, 8'h75, 8'h24, 8'h33};
  bit           kext[NK]  = '{1'b0, 1'b1, 1'b0, 1'b0};

  typedef struct packed {logic [7:0] key; logic make;} evt_t;
  evt_t exp_q[$];

  // Model state after the upcoming edge, and the copy visible during the current cycle.
  bit [NK-1:0] m_down, m_pulse, cur_down, cur_pulse;
  bit          m_ovf, cur_ovf;
  int          m_cnt, cur_cnt;
  bit          ext_pend, brk_pend;
  bit          chk_en = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_push(input int k, input bit mk);
    if (m_cnt < DEPTH) begin
      exp_q.push_back('{key: 8'(k), make: mk});
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic resolve(input byte unsigned b, input bit ext, input bit mk);
    int k = -1;
    for (int i = 0; i < NK; i++) if (k < 0 && codes[i] == b && kext[i] == ext) k = i;
    if (k < 0) return;
    if (mk) begin
      if (!m_down[k] || Typematic) begin
        m_down[k]  = 1'b1;
        m_pulse[k] = 1'b1;
        model_push(k, 1'b1);
      end
    end else if (m_down[k]) begin
      m_down[k] = 1'b0;
      model_push(k, 1'b0);
    end
  endtask

  task automatic feed(input byte unsigned b);
    if (brk_pend) begin
      if (b != 8'hE0 && b != 8'hF0) resolve(b, ext_pend, 1'b0);
      brk_pend = 1'b0;
      ext_pend = 1'b0;
    end else if (b == 8'hF0) begin
      brk_pend = 1'b1;
    end else if (b == 8'hE0) begin
      ext_pend = 1'b1;
    end else begin
      resolve(b, ext_pend, 1'b1);
      ext_pend = 1'b0;
    end
  endtask

  // One clock cycle of stimulus; the model predicts what the next edge produces.
  task automatic step(input bit rst, input bit rx, input byte unsigned b, input bit rdy,
                      input bit clr);
    @(negedge clk);
    reset        = ~rst;
    rx_done_tick = rx;
    din          = b;
    evt_ready    = rdy;
    ovf_clr      = clr;
    if (rst) begin
      m_down   = '0;
      m_pulse  = '0;
      m_ovf    = 1'b0;
      m_cnt    = 0;
      ext_pend = 1'b0;
      brk_pend = 1'b0;
      exp_q.delete();
    end
    cur_down  = m_down;
    cur_pulse = m_pulse;
    cur_ovf   = m_ovf;
    cur_cnt   = m_cnt;
    chk_en    = 1'b1;
    if (rst) return;
    m_pulse = '0;
    if (rdy && m_cnt > 0) m_cnt--;
    if (clr) m_ovf = 1'b0;
    if (rx) feed(b);
  endtask

  task automatic send(input byte unsigned b, input bit rdy);
    step(1'b0, 1'b1, b, rdy, 1'b0);
    step(1'b0, 1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rdy, 1'b0);
  endtask

  // Monitor: compare visible outputs and pop the scoreboard on each accepted event.
  always @(negedge clk) begin
    evt_t e;
    #1;
    if (chk_en) begin
      check("key_down", 32'(key_down), 32'(cur_down));
      check("key_pulse", 32'(key_pulse), 32'(cur_pulse));
      check("evt_valid", 32'(evt_valid), 32'(cur_cnt > 0));
      check("evt_overflow", 32'(evt_overflow), 32'(cur_ovf));
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          check("evt_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("evt_key", 32'(evt_key), 32'(e.key));
          check("evt_make", 32'(evt_make), 32'(e.make));
        end
      end
    end
  end

  byte unsigned pool[11] = '{8'h2C, 8'h75, 8'h24, 8'h33, 8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'hAA,
                             8'h16, 8'hFA};

  initial begin
    reset        = 1'b0;
    din          = 8'h00;
    rx_done_tick = 1'b0;
    evt_ready    = 1'b0;
    ovf_clr      = 1'b0;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("rst_evt_key", 32'(evt_key), 32'd0);
    check("rst_evt_make", 32'(evt_make), 32'd0);
    idle(2, 1'b1);

    // Press/release of key 0.
    send(8'h2C, 1'b1); send(8'hF0, 1'b1); send(8'h2C, 1'b1);
    // Extended key 1: bare code ignored, then E0 make and E0 F0 break.
    send(8'h75, 1'b1);
    send(8'hE0, 1'b1); send(8'h75, 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h75, 1'b1);
    // Typematic repeats on key 2.
    send(8'h24, 1'b1); send(8'h24, 1'b1); send(8'h24, 1'b1);
    send(8'hF0, 1'b1); send(8'h24, 1'b1);
    idle(3, 1'b1);

    // Overflow: five events into a four-deep queue, then clear and drain.
    send(8'h2C, 1'b0); send(8'hF0, 1'b0); send(8'h2C, 1'b0);
    send(8'h2C, 1'b0); send(8'hF0, 1'b0); send(8'h2C, 1'b0);
    send(8'h2C, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(8, 1'b1);

    // Full queue plus a push in the same cycle as a pop.
    send(8'hF0, 1'b0); send(8'h2C, 1'b0); send(8'h2C, 1'b0);
    send(8'hF0, 1'b0); send(8'h2C, 1'b0); send(8'h2C, 1'b0);
    step(1'b0, 1'b1, 8'h24, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Reset mid-sequence: the pending break prefix is discarded.
    send(8'hF0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(2, 1'b1);
    send(8'h2C, 1'b1);
    idle(3, 1'b1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit rst = ($urandom_range(0, 799) == 0);
      bit rx  = !rst && ($urandom_range(0, 2) == 0);
      byte unsigned b = ($urandom_range(0, 9) == 0) ? 8'($urandom) :
                        pool[$urandom_range(0, 10)];
      step(rst, rx, b, $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
    end

    idle(4 * DEPTH, 1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
